// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared types and widths for the UART bus arbiter.
//   arb_state_e  : arbiter FSM state (IDLE, ISSUE, WAIT, GAP)
//   UART_BYTE_W  : width of the UART register port data
//   TMO_CNT_W    : width of the WAIT-state timeout counter (ARB_TIMEOUT_EN builds)
package uart_arb_pkg;

  localparam int UART_BYTE_W = 8;
  localparam int TMO_CNT_W   = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    GAP   = 2'd3
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin requester selection with its own priority pointer.
//   clk, rst_n : clock, asynchronous active-low reset (pointer returns to 0)
//   req        : request vector, one bit per requester
//   upd        : pulse when a transaction completes
//   served     : one-hot owner of the completing transaction (valid with upd)
//   gnt        : one-hot winner, searched from the pointer upwards (combinational)
//   any        : at least one request is present
module rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            upd,
  input  logic [NREQ-1:0] served,
  output logic [NREQ-1:0] gnt,
  output logic            any
);

  localparam int PTR_W = $clog2(NREQ);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NREQ - 1);

  logic [PTR_W-1:0]    ptr_r;
  logic [PTR_W-1:0]    ptr_nxt_s;
  logic [PTR_W-1:0]    served_idx_s;
  logic [2*NREQ-1:0]   req_dbl_s;
  logic [2*NREQ-1:0]   gnt_dbl_s;
  logic [NREQ-1:0]     rot_req_s;
  logic [NREQ-1:0]     rot_gnt_s;

  // Rotate requests so the pointer sits at bit 0, keep the lowest set bit,
  // then rotate the winner back. The doubled vectors make the rotation a shift.
  always_comb begin
    req_dbl_s = {req, req} >> ptr_r;
    rot_req_s = req_dbl_s[NREQ-1:0];
    rot_gnt_s = rot_req_s & (~rot_req_s + NREQ'(1));
    gnt_dbl_s = {rot_gnt_s, rot_gnt_s} << ptr_r;
    gnt       = gnt_dbl_s[2*NREQ-1:NREQ];
    any       = |req;
  end

  // Next pointer: one past the requester just served, wrapping at NREQ.
  always_comb begin
    served_idx_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      served_idx_s = served_idx_s | (served[i] ? PTR_W'(i) : PTR_W'(0));
    end
    if (served_idx_s == PTR_LAST) begin
      ptr_nxt_s = '0;
    end else begin
      ptr_nxt_s = served_idx_s + PTR_W'(1);
    end
  end

  // Priority pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= '0;
    end else if (upd) begin
      ptr_r <= ptr_nxt_s;
    end else begin
      ptr_r <= ptr_r;
    end
  end

endmodule

// File: rtl/uart_bus_arbiter.sv
// uart_bus_arbiter: shares one byte-wide UART register port (en/w_en/r_en/ready)
// between NREQ requesters, one transaction at a time, round-robin.
//   clk, rst_n     : clock, asynchronous active-low reset (aborts any transaction)
//   req_valid/we   : per-requester request level and write flag
//   req_wdata      : per-requester write byte, requester i at [8i+7:8i]
//   req_ready      : one-cycle completion pulse to the served requester
//   req_rdata      : last read byte, held until the next completion
//   req_err        : high with req_ready when the transaction timed out
//   uart_*         : UART register port (uart_en high for the whole access)
//   grant, busy    : current one-hot owner, FSM not idle
// Optional build macro ARB_TIMEOUT_EN: adds a WAIT-state timeout of
// TIMEOUT_CYCLES cycles; without it WAIT lasts until uart_ready and req_err is 0.
module uart_bus_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NREQ           = 2,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NREQ-1:0]             req_valid,
  input  logic [NREQ-1:0]             req_we,
  input  logic [UART_BYTE_W*NREQ-1:0] req_wdata,
  output logic [NREQ-1:0]             req_ready,
  output logic [UART_BYTE_W-1:0]      req_rdata,
  output logic                        req_err,
  output logic                        uart_en,
  output logic                        uart_w_en,
  output logic                        uart_r_en,
  output logic [UART_BYTE_W-1:0]      uart_w_data,
  input  logic [UART_BYTE_W-1:0]      uart_r_data,
  input  logic                        uart_ready,
  output logic [NREQ-1:0]             grant,
  output logic                        busy
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  arb_state_e               state_r, state_nxt_s;
  logic [NREQ-1:0]          grant_r, grant_nxt_s;
  logic                     uart_en_r, en_nxt_s;
  logic                     uart_w_en_r, w_en_nxt_s;
  logic                     uart_r_en_r, r_en_nxt_s;
  logic [UART_BYTE_W-1:0]   uart_w_data_r, w_data_nxt_s;
  logic [UART_BYTE_W-1:0]   req_rdata_r, rdata_nxt_s;
  logic [NREQ-1:0]          req_ready_r, ready_nxt_s;
  logic                     req_err_r, err_nxt_s;
  logic                     busy_r;
  logic [GAP_W-1:0]         gap_cnt_r, gap_nxt_s;
  logic                     upd_s;
  logic [NREQ-1:0]          gnt_s;
  logic                     any_s;
  logic                     sel_we_s;
  logic [UART_BYTE_W-1:0]   sel_wdata_s;
  logic                     tmo_hit_s;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req_valid),
    .upd    (upd_s),
    .served (grant_r),
    .gnt    (gnt_s),
    .any    (any_s)
  );

  // One-hot mux of the winning requester's write flag and byte.
  always_comb begin
    sel_we_s    = 1'b0;
    sel_wdata_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      sel_we_s    = sel_we_s | (gnt_s[i] & req_we[i]);
      sel_wdata_s = sel_wdata_s
                  | (req_wdata[i*UART_BYTE_W +: UART_BYTE_W] & {UART_BYTE_W{gnt_s[i]}});
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam logic [TMO_CNT_W-1:0] TMO_LAST = TMO_CNT_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_CNT_W-1:0] tmo_cnt_r;

  // WAIT cycle counter; held at zero elsewhere so it is clear on WAIT entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_r <= '0;
    end else if (state_r == WAIT) begin
      tmo_cnt_r <= tmo_cnt_r + TMO_CNT_W'(1);
    end else begin
      tmo_cnt_r <= '0;
    end
  end

  assign tmo_hit_s = (state_r == WAIT) && (tmo_cnt_r == TMO_LAST);
`else
  assign tmo_hit_s = 1'b0;
`endif

  // Next state and next values of every registered output.
  always_comb begin
    state_nxt_s  = state_r;
    grant_nxt_s  = grant_r;
    en_nxt_s     = uart_en_r;
    w_en_nxt_s   = uart_w_en_r;
    r_en_nxt_s   = uart_r_en_r;
    w_data_nxt_s = uart_w_data_r;
    rdata_nxt_s  = req_rdata_r;
    ready_nxt_s  = '0;
    err_nxt_s    = 1'b0;
    gap_nxt_s    = gap_cnt_r;
    upd_s        = 1'b0;
    case (state_r)
      IDLE: begin
        if (any_s) begin
          grant_nxt_s  = gnt_s;
          en_nxt_s     = 1'b1;
          w_en_nxt_s   = sel_we_s;
          r_en_nxt_s   = ~sel_we_s;
          w_data_nxt_s = sel_wdata_s;
          state_nxt_s  = ISSUE;
        end else begin
          state_nxt_s  = IDLE;
        end
      end
      // The UART cannot answer this early, so uart_ready is not looked at here.
      ISSUE: begin
        state_nxt_s = WAIT;
      end
      WAIT: begin
        if (uart_ready || tmo_hit_s) begin
          ready_nxt_s = grant_r;
          grant_nxt_s = '0;
          en_nxt_s    = 1'b0;
          w_en_nxt_s  = 1'b0;
          r_en_nxt_s  = 1'b0;
          upd_s       = 1'b1;
          gap_nxt_s   = '0;
          state_nxt_s = GAP;
          // A real answer beats a coincident expiry.
          if (uart_ready) begin
            err_nxt_s = 1'b0;
            if (uart_r_en_r) begin
              rdata_nxt_s = uart_r_data;
            end else begin
              rdata_nxt_s = req_rdata_r;
            end
          end else begin
            err_nxt_s   = 1'b1;
            rdata_nxt_s = '0;
          end
        end else begin
          state_nxt_s = WAIT;
        end
      end
      GAP: begin
        if (gap_cnt_r == GAP_LAST) begin
          gap_nxt_s   = '0;
          state_nxt_s = IDLE;
        end else begin
          gap_nxt_s   = gap_cnt_r + GAP_W'(1);
          state_nxt_s = GAP;
        end
      end
      default: begin
        grant_nxt_s = '0;
        en_nxt_s    = 1'b0;
        w_en_nxt_s  = 1'b0;
        r_en_nxt_s  = 1'b0;
        gap_nxt_s   = '0;
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      grant_r       <= '0;
      uart_en_r     <= 1'b0;
      uart_w_en_r   <= 1'b0;
      uart_r_en_r   <= 1'b0;
      uart_w_data_r <= '0;
      req_rdata_r   <= '0;
      req_ready_r   <= '0;
      req_err_r     <= 1'b0;
      busy_r        <= 1'b0;
      gap_cnt_r     <= '0;
    end else begin
      state_r       <= state_nxt_s;
      grant_r       <= grant_nxt_s;
      uart_en_r     <= en_nxt_s;
      uart_w_en_r   <= w_en_nxt_s;
      uart_r_en_r   <= r_en_nxt_s;
      uart_w_data_r <= w_data_nxt_s;
      req_rdata_r   <= rdata_nxt_s;
      req_ready_r   <= ready_nxt_s;
      req_err_r     <= err_nxt_s;
      busy_r        <= (state_nxt_s != IDLE);
      gap_cnt_r     <= gap_nxt_s;
    end
  end

  assign grant       = grant_r;
  assign uart_en     = uart_en_r;
  assign uart_w_en   = uart_w_en_r;
  assign uart_r_en   = uart_r_en_r;
  assign uart_w_data = uart_w_data_r;
  assign req_rdata   = req_rdata_r;
  assign req_ready   = req_ready_r;
  assign req_err     = req_err_r;
  assign busy        = busy_r;

endmodule
